// File: rtl/writeback_scoreboard_if.sv
// Purpose : Valid/ready handshake bundle between a long-latency unit
//           (divider, FPU) and the write-back scoreboard.
// Signals : mc_valid  - result valid from the long-latency unit
//           mc_rd     - destination register of the result
//           mc_data   - result data
//           mc_ready  - scoreboard can accept a result this cycle
// Modports: master = long-latency unit, slave = writeback_scoreboard
interface writeback_scoreboard_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  mc_valid;
    logic [ADDR_WIDTH-1:0] mc_rd;
    logic [DATA_WIDTH-1:0] mc_data;
    logic                  mc_ready;

    modport master (
        output mc_valid,
        output mc_rd,
        output mc_data,
        input  mc_ready
    );

    modport slave (
        input  mc_valid,
        input  mc_rd,
        input  mc_data,
        output mc_ready
    );
endinterface

// File: rtl/writeback_scoreboard.sv
// Purpose : Owns the register-file write port. Merges single-cycle pipeline
//           write-backs with long-latency results, keeps a busy bit per
//           register for outstanding long-latency writes and raises a
//           RAW/WAW stall request towards ID.
// Ports   : clk, reset             - clock, synchronous active-high reset
//           rs1/rs2/rs3_rena_ID,
//           rs1/rs2/rs3_addr_ID    - ID source operand reads
//           rd_wena_ID, rd_addr_ID - ID destination write
//           issue_valid, issue_rd  - long-latency op issued; rd becomes busy
//           rd_wena_WB, rd_addr_WB,
//           rd_data_WB             - pipeline write-back (never stalled)
//           mc_if                  - long-latency result handshake (slave)
//           rf_wena/rf_waddr/
//           rf_wdata               - registered register-file write port
//           hazard_ID              - ID must stall
module writeback_scoreboard #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rs1_rena_ID,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_ID,
    input  logic                  rs2_rena_ID,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_ID,
    input  logic                  rs3_rena_ID,
    input  logic [ADDR_WIDTH-1:0] rs3_addr_ID,
    input  logic                  rd_wena_ID,
    input  logic [ADDR_WIDTH-1:0] rd_addr_ID,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  rd_wena_WB,
    input  logic [ADDR_WIDTH-1:0] rd_addr_WB,
    input  logic [DATA_WIDTH-1:0] rd_data_WB,
    writeback_scoreboard_if.slave mc_if,
    output logic                  rf_wena,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  hazard_ID
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0]   busy_q,     busy_d;
    logic                  buf_full_q, buf_full_d;
    logic [ADDR_WIDTH-1:0] buf_rd_q,   buf_rd_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  rf_wena_q,  rf_wena_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  mc_accept;

    // The buffer is only one deep, so a new result can never be accepted
    // while an older one is still waiting for the write port.
    assign mc_if.mc_ready = !buf_full_q;
    assign mc_accept      = mc_if.mc_valid && !buf_full_q;

    assign rf_wena  = rf_wena_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // x0 is hardwired, so it never stalls even if its busy bit were set.
    always_comb begin
        hazard_ID = (rs1_rena_ID && (rs1_addr_ID != '0) && busy_q[rs1_addr_ID])
                 || (rs2_rena_ID && (rs2_addr_ID != '0) && busy_q[rs2_addr_ID])
                 || (rs3_rena_ID && (rs3_addr_ID != '0) && busy_q[rs3_addr_ID])
                 || (rd_wena_ID  && (rd_addr_ID  != '0) && busy_q[rd_addr_ID]);
    end

    // Write-port arbitration: pipeline write-back first, then the buffered
    // long-latency result, then a freshly accepted one. A busy bit clears
    // only when its result actually wins the port, so readers keep stalling
    // while the result sits in the buffer. The issue set is applied last so
    // it overrides a clear of the same register in the same cycle.
    always_comb begin
        busy_d     = busy_q;
        buf_full_d = buf_full_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        rf_wena_d  = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (rd_wena_WB) begin
            rf_wena_d  = 1'b1;
            rf_waddr_d = rd_addr_WB;
            rf_wdata_d = rd_data_WB;
            if (mc_accept) begin
                buf_full_d = 1'b1;
                buf_rd_d   = mc_if.mc_rd;
                buf_data_d = mc_if.mc_data;
            end
        end else if (buf_full_q) begin
            rf_wena_d        = 1'b1;
            rf_waddr_d       = buf_rd_q;
            rf_wdata_d       = buf_data_q;
            buf_full_d       = 1'b0;
            busy_d[buf_rd_q] = 1'b0;
        end else if (mc_accept) begin
            rf_wena_d            = 1'b1;
            rf_waddr_d           = mc_if.mc_rd;
            rf_wdata_d           = mc_if.mc_data;
            busy_d[mc_if.mc_rd]  = 1'b0;
        end

        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    // State register; reset drops any buffered result and all busy bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            buf_full_q <= 1'b0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            rf_wena_q  <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            busy_q     <= busy_d;
            buf_full_q <= buf_full_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            rf_wena_q  <= rf_wena_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Purpose : Directed self-checking bench for writeback_scoreboard. Expected
//           register-file writes are queued when stimulus is driven and
//           compared in order as the DUT produces them; every clock without
//           a queued write must show rf_wena=0.
module tb_writeback_scoreboard;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        rs1_rena_ID, rs2_rena_ID, rs3_rena_ID, rd_wena_ID;
    logic [5:0]  rs1_addr_ID, rs2_addr_ID, rs3_addr_ID, rd_addr_ID;
    logic        issue_valid;
    logic [5:0]  issue_rd;
    logic        rd_wena_WB;
    logic [5:0]  rd_addr_WB;
    logic [31:0] rd_data_WB;
    logic        rf_wena;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hazard_ID;

    wr_t exp_q[$];
    int  assert_count = 0;
    int  fail_count   = 0;

    writeback_scoreboard_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) mc_if ();

    writeback_scoreboard #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs1_rena_ID (rs1_rena_ID),
        .rs1_addr_ID (rs1_addr_ID),
        .rs2_rena_ID (rs2_rena_ID),
        .rs2_addr_ID (rs2_addr_ID),
        .rs3_rena_ID (rs3_rena_ID),
        .rs3_addr_ID (rs3_addr_ID),
        .rd_wena_ID  (rd_wena_ID),
        .rd_addr_ID  (rd_addr_ID),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rd_wena_WB  (rd_wena_WB),
        .rd_addr_WB  (rd_addr_WB),
        .rd_data_WB  (rd_data_WB),
        .mc_if       (mc_if),
        .rf_wena     (rf_wena),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .hazard_ID   (hazard_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One counted comparison.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive every DUT input to its inactive value.
    task automatic idle_inputs();
        rs1_rena_ID      = 1'b0; rs1_addr_ID = '0;
        rs2_rena_ID      = 1'b0; rs2_addr_ID = '0;
        rs3_rena_ID      = 1'b0; rs3_addr_ID = '0;
        rd_wena_ID       = 1'b0; rd_addr_ID  = '0;
        issue_valid      = 1'b0; issue_rd    = '0;
        rd_wena_WB       = 1'b0; rd_addr_WB  = '0; rd_data_WB = '0;
        mc_if.mc_valid   = 1'b0; mc_if.mc_rd = '0; mc_if.mc_data = '0;
    endtask

    task automatic apply_stimulus(input logic wb, input logic [5:0] wb_a, input logic [31:0] wb_d,
                                  input logic mc, input logic [5:0] mc_a, input logic [31:0] mc_d,
                                  input logic iss, input logic [5:0] iss_a);
        rd_wena_WB     = wb;  rd_addr_WB  = wb_a; rd_data_WB    = wb_d;
        mc_if.mc_valid = mc;  mc_if.mc_rd = mc_a; mc_if.mc_data = mc_d;
        issue_valid    = iss; issue_rd    = iss_a;
    endtask

    task automatic expect_write(input logic [5:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Advance one clock and compare the registered write port with the
    // oldest outstanding expectation (or with "no write").
    task automatic tick(input string tag);
        wr_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_output({tag, ".rf_wena"},  {31'b0, rf_wena}, 32'd1);
            check_output({tag, ".rf_waddr"}, {26'b0, rf_waddr}, {26'b0, e.addr});
            check_output({tag, ".rf_wdata"}, rf_wdata, e.data);
        end else begin
            check_output({tag, ".rf_wena_idle"}, {31'b0, rf_wena}, 32'd0);
        end
    endtask

    task automatic check_hazard(input string tag, input logic expected);
        #1;
        check_output(tag, {31'b0, hazard_ID}, {31'b0, expected});
    endtask

    task automatic check_ready(input string tag, input logic expected);
        #1;
        check_output(tag, {31'b0, mc_if.mc_ready}, {31'b0, expected});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick("reset0");
        tick("reset1");
        reset = 1'b0;
        check_output("reset.rf_waddr", {26'b0, rf_waddr}, 32'd0);
        check_output("reset.rf_wdata", rf_wdata, 32'd0);
        check_ready("reset.mc_ready", 1'b1);
        $display("[TB] reset checked");

        // Plain pipeline write-back, latency one.
        apply_stimulus(1'b1, 6'd5, 32'h1234, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0);
        expect_write(6'd5, 32'h1234);
        tick("wb_x5");
        idle_inputs();
        tick("wb_x5_after");

        // Issue to x7, RAW and WAW stalls, then the result clears it.
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd7);
        tick("issue_x7");
        idle_inputs();
        rs2_rena_ID = 1'b1; rs2_addr_ID = 6'd7;
        check_hazard("raw_x7", 1'b1);
        rs2_rena_ID = 1'b0;
        rd_wena_ID = 1'b1; rd_addr_ID = 6'd7;
        check_hazard("waw_x7", 1'b1);
        rd_wena_ID = 1'b0;
        rs2_addr_ID = 6'd7;
        check_hazard("x7_no_rena", 1'b0);
        rs2_rena_ID = 1'b1;
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 32'hAA, 1'b0, 6'd0);
        check_ready("mc_x7.ready", 1'b1);
        expect_write(6'd7, 32'hAA);
        tick("mc_x7");
        mc_if.mc_valid = 1'b0;
        check_hazard("x7_cleared", 1'b0);
        idle_inputs();

        // Collision: mc x9 buffered behind WB x3; x9 stays busy until written.
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd9);
        tick("issue_x9");
        apply_stimulus(1'b1, 6'd3, 32'h11, 1'b1, 6'd9, 32'h55, 1'b0, 6'd0);
        expect_write(6'd3, 32'h11);
        expect_write(6'd9, 32'h55);
        tick("coll_x3");
        idle_inputs();
        check_ready("coll.ready_full", 1'b0);
        rs1_rena_ID = 1'b1; rs1_addr_ID = 6'd9;
        check_hazard("x9_busy_in_buf", 1'b1);
        tick("coll_x9");
        check_ready("coll.ready_drained", 1'b1);
        check_hazard("x9_cleared", 1'b0);
        idle_inputs();

        // Buffer held across back-to-back WB; mc_valid ignored while full.
        apply_stimulus(1'b1, 6'd3, 32'h21, 1'b1, 6'd10, 32'hA0, 1'b0, 6'd0);
        expect_write(6'd3, 32'h21);
        expect_write(6'd4, 32'h22);
        expect_write(6'd10, 32'hA0);
        expect_write(6'd11, 32'hB0);
        tick("hold_x3");
        apply_stimulus(1'b1, 6'd4, 32'h22, 1'b1, 6'd11, 32'hB0, 1'b0, 6'd0);
        tick("hold_x4");
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd11, 32'hB0, 1'b0, 6'd0);
        tick("hold_x10");
        tick("hold_x11");
        idle_inputs();
        tick("hold_idle");

        // x0 is never busy; f0 (32) is an ordinary register.
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd0);
        tick("issue_x0");
        idle_inputs();
        rs1_rena_ID = 1'b1; rs1_addr_ID = 6'd0;
        rd_wena_ID  = 1'b1; rd_addr_ID  = 6'd0;
        check_hazard("x0_never_busy", 1'b0);
        idle_inputs();
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd32);
        tick("issue_f0");
        idle_inputs();
        rs3_rena_ID = 1'b1; rs3_addr_ID = 6'd32;
        check_hazard("f0_busy", 1'b1);
        rs3_addr_ID = 6'd0;
        check_hazard("x0_not_aliased", 1'b0);
        idle_inputs();

        // Same-edge clear and set of x12: set wins.
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd12);
        tick("issue_x12");
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd12, 32'h77, 1'b1, 6'd12);
        expect_write(6'd12, 32'h77);
        tick("x12_set_clear");
        idle_inputs();
        rs1_rena_ID = 1'b1; rs1_addr_ID = 6'd12;
        check_hazard("x12_set_wins", 1'b1);
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd12, 32'h78, 1'b0, 6'd0);
        expect_write(6'd12, 32'h78);
        tick("x12_final");
        idle_inputs();
        rs1_rena_ID = 1'b1; rs1_addr_ID = 6'd12;
        check_hazard("x12_cleared", 1'b0);
        idle_inputs();

        // Reset while x9 sits in the buffer (f0 is still busy too).
        apply_stimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd9);
        tick("issue_x9b");
        apply_stimulus(1'b1, 6'd3, 32'h31, 1'b1, 6'd9, 32'h99, 1'b0, 6'd0);
        expect_write(6'd3, 32'h31);
        tick("rst_x3");
        idle_inputs();
        check_ready("rst.ready_full", 1'b0);
        reset = 1'b1;
        tick("rst_edge");
        reset = 1'b0;
        check_ready("rst.ready_after", 1'b1);
        for (int i = 1; i < 64; i++) begin
            rs1_rena_ID = 1'b1;
            rs1_addr_ID = i[5:0];
            check_hazard($sformatf("rst.busy_%0d", i), 1'b0);
        end
        idle_inputs();
        tick("rst_no_x9_a");
        tick("rst_no_x9_b");

        check_output("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
